// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential restoring divider.
// Holds the controller state encoding, the operand width, the iteration
// counter width and a two's-complement negation helper.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  // Two's-complement negation; -(2^(W-1)) maps onto itself, which is the
  // wanted unsigned magnitude for the most negative operand.
  function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] v);
    return ~v + DIV_WIDTH'(1);
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: start/busy/done handshake plus operand and result bus
// between the control unit (master) and the divider (slave).
interface div_seq_ctrl_if;
  import div_pkg::*;

  logic                     start;
  logic [DIV_WIDTH-1:0]     dividend;
  logic [DIV_WIDTH-1:0]     divisor;
  logic                     busy;
  logic                     done;
  logic                     div_by_zero;
  logic [2*DIV_WIDTH-1:0]   Z;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, Z
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, Z
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts {A,Q} left by one, trial-subtracts M from A and either keeps the
// difference (quotient bit 1) or restores A (quotient bit 0).
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  // Shifted partial remainder carries one extra bit so the trial compare
  // stays exact even for divisors near 2^WIDTH in the unsigned build.
  logic [WIDTH+1:0] a_sh_s;

  // Shift, trial-subtract and restore-or-keep decision.
  always_comb begin
    a_sh_s = {a_i, q_i[WIDTH-1]};
    if (a_sh_s >= {2'b00, m_i}) begin
      a_o = (WIDTH+1)'(a_sh_s - {2'b00, m_i});
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      a_o = a_sh_s[WIDTH:0];
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multicycle restoring divider controller for DIV.
// IDLE -> PREP -> ITER (WIDTH steps) -> FIX -> DONE, or PREP -> DONE on a
// zero divisor. Z = {remainder, quotient}.
// Build option: define DIV_SIGNED_EN for signed two's-complement division;
// undefined gives unsigned division with identical states and latency.
module div_seq_ctrl
  import div_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  div_seq_ctrl_if.slave     bus
);

  localparam int WIDTH = DIV_WIDTH;

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [WIDTH:0]         a_q, a_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [WIDTH-1:0]       m_q, m_d;
  logic [WIDTH-1:0]       dvd_q, dvd_d;
  logic [WIDTH-1:0]       dvs_q, dvs_d;
  logic [2*WIDTH-1:0]     z_q, z_d;
  logic                   dbz_q, dbz_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef DIV_SIGNED_EN
  logic                   qneg_q, qneg_d;
  logic                   rneg_q, rneg_d;
`endif

  logic [WIDTH:0]         a_step_s;
  logic [WIDTH-1:0]       q_step_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a_i (a_q),
    .q_i (q_q),
    .m_i (m_q),
    .a_o (a_step_s),
    .q_o (q_step_s)
  );

  // Next-state, datapath load and result formation for each state.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    z_d     = z_q;
    dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          state_d = PREP;
        end else begin
          state_d = IDLE;
        end
      end
      PREP: begin
        if (dvs_q == {WIDTH{1'b0}}) begin
          z_d     = {dvd_q, {WIDTH{1'b1}}};
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          a_d     = {(WIDTH+1){1'b0}};
          count_d = {CNT_W{1'b0}};
`ifdef DIV_SIGNED_EN
          q_d     = dvd_q[WIDTH-1] ? twos_neg(dvd_q) : dvd_q;
          m_d     = dvs_q[WIDTH-1] ? twos_neg(dvs_q) : dvs_q;
          qneg_d  = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
          rneg_d  = dvd_q[WIDTH-1];
`else
          q_d     = dvd_q;
          m_d     = dvs_q;
`endif
          state_d = ITER;
        end
      end
      ITER: begin
        a_d = a_step_s;
        q_d = q_step_s;
        if (count_q == CNT_W'(WIDTH-1)) begin
          state_d = FIX;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
      FIX: begin
`ifdef DIV_SIGNED_EN
        z_d = {(rneg_q ? twos_neg(a_q[WIDTH-1:0]) : a_q[WIDTH-1:0]),
               (qneg_q ? twos_neg(q_q) : q_q)};
`else
        z_d = {a_q[WIDTH-1:0], q_q};
`endif
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are registered copies derived from the next state.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      count_q <= {CNT_W{1'b0}};
      a_q     <= {(WIDTH+1){1'b0}};
      q_q     <= {WIDTH{1'b0}};
      m_q     <= {WIDTH{1'b0}};
      dvd_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      z_q     <= {(2*WIDTH){1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      z_q     <= z_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.Z           = z_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and randomized checks of div_seq_ctrl against a
// plain-arithmetic reference (signed or unsigned per DIV_SIGNED_EN).
module tb_div_seq_ctrl;

  logic clk;
  logic clr;
  int   checks;
  int   failures;

  div_seq_ctrl_if bus ();

  div_seq_ctrl dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {div_by_zero, remainder, quotient}.
  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SIGNED_EN
    longint sa, sb, sq, sr;
`endif
    if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
`ifdef DIV_SIGNED_EN
    sa = $signed(a);
    sb = $signed(b);
    sq = sa / sb;
    sr = sa % sb;
    return {1'b0, sr[31:0], sq[31:0]};
`else
    return {1'b0, a % b, a / b};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One division: accept, watch busy each edge, check latency and result,
  // then check the done pulse ends, Z holds and optional start-in-DONE is ignored.
  task automatic run_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic [63:0] exp_z, input logic exp_dbz, input int exp_edge,
                         input bit repulse, input bit start_in_done);
    int done_edge;
    bit busy_ok;
    done_edge = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    busy_ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
    for (int e = 2; e <= 45 && done_edge == 0; e++) begin
      if (repulse && e == 10) begin
        bus.start    = 1'b1;
        bus.dividend = $urandom;
        bus.divisor  = $urandom_range(1, 9);
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) done_edge = e;
    end
    check({tag, "/done_edge"}, 64'(done_edge), 64'(exp_edge));
    check({tag, "/busy_span"}, 64'(busy_ok), 64'd1);
    check({tag, "/Z"}, bus.Z, exp_z);
    check({tag, "/dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    if (start_in_done) begin
      bus.start    = 1'b1;
      bus.dividend = $urandom;
      bus.divisor  = 32'd3;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "/done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, "/busy_idle"}, 64'(bus.busy), 64'd0);
    check({tag, "/Z_hold"}, bus.Z, exp_z);
  endtask

  task automatic run_model(input string tag, input logic [31:0] dvd, input logic [31:0] dvs);
    logic [64:0] r;
    r = model(dvd, dvs);
    run_div(tag, dvd, dvs, r[63:0], r[64], (dvs == 32'd0) ? 2 : 35, 1'b0, 1'b0);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    clr          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    check("reset/busy", 64'(bus.busy), 64'd0);
    check("reset/done", 64'(bus.done), 64'd0);
    check("reset/dbz", 64'(bus.div_by_zero), 64'd0);
    check("reset/Z", bus.Z, 64'd0);

    // Basic case, then with a start re-pulse mid-operation and start in DONE.
    run_div("100div7", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 35, 1'b0, 1'b0);
    run_div("100div7_repulse", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 35, 1'b1, 1'b1);

    // Divide by zero.
    run_div("5div0", 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 1'b1, 2, 1'b0, 1'b0);

    // Abort with clr at edge 12 of an operation.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr/busy", 64'(bus.busy), 64'd0);
    check("clr/done", 64'(bus.done), 64'd0);
    check("clr/Z", bus.Z, 64'd0);
    check("clr/dbz", 64'(bus.div_by_zero), 64'd0);
    run_div("9div3", 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, 35, 1'b0, 1'b0);

`ifdef DIV_SIGNED_EN
    run_div("m7div2", 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 35, 1'b0, 1'b0);
    run_div("7divm2", 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 35, 1'b0, 1'b0);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 35, 1'b0, 1'b0);
    run_div("min_div_min", 32'h8000_0000, 32'h8000_0000, {32'd0, 32'd1}, 1'b0, 35, 1'b0, 1'b0);
`else
    run_div("max_div2", 32'hFFFF_FFFF, 32'd2, {32'd1, 32'h7FFF_FFFF}, 1'b0, 35, 1'b0, 1'b0);
    run_div("max_div_big", 32'hFFFF_FFFF, 32'hFFFF_FFFE, {32'd1, 32'd1}, 1'b0, 35, 1'b0, 1'b0);
`endif
    run_model("min_div_one", 32'h8000_0000, 32'd1);

    // Randomized operands against the reference.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      int sel;
      a   = $urandom;
      sel = $urandom_range(0, 3);
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) b = $urandom_range(1, 15);
      else               b = $urandom;
      run_model("rand", a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
